// File: rtl/cs_pkg.sv
// Shared constants and types for the CS computational block and its output stage.
package cs_pkg;

  localparam int unsigned CS_YW     = 10;
  localparam int unsigned CS_WIN    = 9;
  localparam int unsigned CS_WARMUP = CS_WIN - 1;

  typedef logic [CS_YW-1:0] cs_y_t;

  // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
  function automatic int unsigned cs_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cs_buf_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module cs_buf_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Cleared on reset so the fall-through output reads 0 while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cs_out_buffer.sv
// First-word-fall-through output FIFO for the CS result stream with overflow flag.
// Define CS_WARMUP_SKIP_EN to discard the results produced before the window fills.
module cs_out_buffer
  import cs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = CS_YW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           Y,
  input  logic                   in_en,
  output logic [W-1:0]           dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("cs_out_buffer: DEPTH must be a power of two in 2..64");
  end
  if (W != CS_YW || CW != cs_count_width(DEPTH)) begin : g_width_chk
    $error("cs_out_buffer: W must equal the CS result width");
  end

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic          push_req;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          is_full;
  logic          is_empty;

`ifdef CS_WARMUP_SKIP_EN
  logic [3:0] warm_q;
  logic       warm_discard;

  assign warm_discard = (warm_q < 4'(CS_WARMUP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
    end else if (in_en && warm_q != 4'hf) begin
      warm_q <= warm_q + 4'd1;
    end
  end

  assign push_req = in_en & ~warm_discard;
`else
  assign push_req = in_en;
`endif

  assign is_full  = (count_q == DepthC);
  assign is_empty = (count_q == '0);
  assign pop      = ~is_empty & dout_ready;
  // When full, the slot vacated by a same-cycle pop is the one wr_ptr points at.
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  cs_buf_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (Y),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign dout_valid = ~is_empty;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign count      = count_q;

endmodule

// File: tb/tb_cs_out_buffer.sv
// Self-checking bench for cs_out_buffer: queue-based reference model plus literal checks.
module tb_cs_out_buffer;

  localparam int DEPTH = 8;
  localparam int W     = 10;

  logic         clk;
  logic         reset;
  logic [W-1:0] y;
  logic         in_en;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         full;
  logic         overflow;
  logic [3:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int m_ovf  = 0;
  int m_warm = 0;
  int m_size;
  bit m_pop;
  bit m_req;
  bit started = 0;

  cs_out_buffer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Y          (y),
    .in_en      (in_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .overflow   (overflow),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue, advanced with the inputs sampled at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf  = 0;
      m_warm = 0;
    end else begin
      m_size = q.size();
      m_pop  = (m_size > 0) && dout_ready;
      m_req  = in_en;
`ifdef CS_WARMUP_SKIP_EN
      if (in_en) begin
        if (m_warm < 8) m_req = 1'b0;
        m_warm++;
      end
`endif
      if (m_pop) void'(q.pop_front());
      if (m_req) begin
        if (m_size < DEPTH || m_pop) q.push_back(int'(y));
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      check("cmp_count", 32'(count), q.size());
      check("cmp_valid", 32'(dout_valid), 32'(q.size() != 0));
      check("cmp_full", 32'(full), 32'(q.size() == DEPTH));
      check("cmp_overflow", 32'(overflow), m_ovf);
      if (q.size() != 0) check("cmp_dout", 32'(dout), q[0]);
    end
  end

  task automatic step(input logic e, input logic [W-1:0] v, input logic r);
    in_en      = e;
    y          = v;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string name, input int exp);
    check({name, "_valid"}, 32'(dout_valid), 1);
    check(name, 32'(dout), exp);
    step(1'b0, '0, 1'b1);
  endtask

  // Reset asserted asynchronously, mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    in_en      = 1'b0;
    dout_ready = 1'b0;
    y          = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_dout", 32'(dout), 0);
    q.delete();
    m_ovf  = 0;
    m_warm = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic warm_fill();
`ifdef CS_WARMUP_SKIP_EN
    repeat (8) step(1'b1, '0, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    in_en      = 1'b0;
    dout_ready = 1'b0;
    y          = '0;
    @(negedge clk);
    reset = 1'b0;
    started = 1'b1;
    do_reset();

    // Warm-up behaviour: 12 strobes, no consumer.
    for (int i = 1; i <= 12; i++) step(1'b1, W'(i), 1'b0);
`ifdef CS_WARMUP_SKIP_EN
    check("warm_count", 32'(count), 4);
    check("warm_overflow", 32'(overflow), 0);
    for (int i = 9; i <= 12; i++) pop_expect("warm_pop", i);
`else
    check("warm_count", 32'(count), 8);
    check("warm_full", 32'(full), 1);
    check("warm_overflow", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) pop_expect("warm_pop", i);
`endif
    check("warm_drained", 32'(dout_valid), 0);

    // Reset with data held in the FIFO.
    for (int i = 0; i < 3; i++) step(1'b1, W'(500 + i), 1'b0);
    check("midrst_count_before", 32'(count), 3);
    do_reset();

    // Overflow: 10 pushes into an 8-deep FIFO.
    warm_fill();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(100 + i), 1'b0);
      if (i == 7) begin
        check("ovf_full_8th", 32'(full), 1);
        check("ovf_flag_8th", 32'(overflow), 0);
      end
      if (i == 8) check("ovf_flag_9th", 32'(overflow), 1);
    end
    step(1'b0, '0, 1'b0);
    check("ovf_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) pop_expect("ovf_pop", 100 + i);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_empty", 32'(count), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    warm_fill();
    for (int i = 0; i < 8; i++) step(1'b1, W'(i), 1'b0);
    check("fullpp_full", 32'(full), 1);
    check("fullpp_head", 32'(dout), 0);
    step(1'b1, W'(8), 1'b1);
    check("fullpp_count", 32'(count), 8);
    check("fullpp_overflow", 32'(overflow), 0);
    check("fullpp_newhead", 32'(dout), 1);
    for (int i = 1; i <= 8; i++) pop_expect("fullpp_pop", i);

    // Streaming: occupancy never above one, data falls straight through.
    for (int n = 0; n < 64; n++) begin
      step(1'b1, W'(n), 1'b1);
      check("stream_count_le1", 32'(count <= 1), 1);
      check("stream_dout", 32'(dout), n);
    end
    step(1'b0, '0, 1'b1);
    check("stream_drained", 32'(count), 0);

    // Random back-pressure with continuous input, then random input strobes.
    do_reset();
    warm_fill();
    for (int i = 0; i < 400; i++) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
    repeat (DEPTH + 1) step(1'b0, '0, 1'b1);
    check("rand_drained", 32'(count), 0);

    started = 1'b0;
    step(1'b0, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
